imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction memory address width (256 words).
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 Parameter FILL_WORD, default 16'h0000, word written to unloaded addresses (NOP encoding).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load_start  input  1  single-cycle request to begin a program load.
REQ-007 host_valid  input  1  host word available.
REQ-008 host_data  input  DATA_W  instruction word from host.
REQ-009 host_last  input  1  qualifies the final word of the program.
REQ-010 host_ready  output  1  loader accepts a host word this cycle.
REQ-011 mem_we  output  1  instruction memory write enable.
REQ-012 mem_waddr  output  ADDR_W  instruction memory write address.
REQ-013 mem_wdata  output  DATA_W  instruction memory write data.
REQ-014 cpu_halt  input  1  CPU has retired a HALT instruction.
REQ-015 cpu_run  output  1  CPU allowed to fetch/execute; CPU held in reset while low.
REQ-016 load_count  output  ADDR_W+1  words accepted from host in the last load (0..256).
REQ-017 busy  output  1  high in LOAD or FILL.

Function
REQ-018 States: IDLE, LOAD, FILL, RUN, DONE; IDLE after reset.
REQ-019 IDLE/DONE: load_start=1 -> LOAD; address counter and load_count cleared to 0 on that edge.
REQ-020 LOAD: host_ready=1; transfer occurs on host_valid&host_ready.
REQ-021 Each transfer: mem_we=1, mem_waddr=counter, mem_wdata=host_data registered, visible exactly one cycle after the transfer edge; counter and load_count increment.
REQ-022 Transfer with host_last=1 at counter<255 -> FILL with counter+1.
REQ-023 Transfer at counter=255 (host_last ignored) -> RUN directly; no FILL.
REQ-024 FILL: host_ready=0; one write per cycle of FILL_WORD at counter, incrementing; write at 255 -> RUN.
REQ-025 RUN: cpu_run=1; cpu_halt=1 -> DONE, cpu_run=0 from next cycle.
REQ-026 cpu_run=1 only in RUN; host_ready=1 only in LOAD; mem_we=0 in all other cycles.
REQ-027 load_start ignored in LOAD, FILL and RUN; cpu_halt ignored outside RUN.
REQ-028 Counter width ADDR_W; never wraps: terminal address 255 always ends the write phase.
REQ-029 load_count holds its value through FILL, RUN and DONE until next load_start.
REQ-030 LOAD with host_valid never asserted: remains in LOAD indefinitely, no writes.

Reset
REQ-031 reset=1 -> next state IDLE; cpu_run, host_ready, mem_we, busy = 0; mem_waddr, mem_wdata, load_count, counter = 0.
REQ-032 reset has priority over every other input, including mid-LOAD/FILL; a pending registered write is dropped; memory contents left partial and are not cleared.

Structure
REQ-033 State encoding, ADDR_W/DATA_W defaults and the NOP/HALT opcode constants live in the shared CPU package with the other opcode definitions.
REQ-034 Single module; no sub-module; the instruction memory is instantiated by the parent, not inside this block.

Verification
REQ-035 Reset, load_start, 3 words 0x4A09,0x4A89,0x0800(last) with host_valid continuous -> writes addr 0..2 with those words one cycle after each transfer, then 253 FILL writes of 0x0000 to addr 3..255, cpu_run rises the cycle after the addr-255 write, load_count=3.
REQ-036 256 words without host_last -> no FILL writes, RUN after word 255, load_count=256, host_ready low after word 255.
REQ-037 host_valid toggled 1/0 each cycle during LOAD -> write only on accepted cycles, addresses contiguous, no duplicates.
REQ-038 In RUN assert cpu_halt -> cpu_run=0 next cycle, state DONE; second load_start -> new load from addr 0, load_count restarts.
REQ-039 reset asserted after 5 of 10 words -> all outputs zero next cycle, state IDLE, no further mem_we until a new load_start.
REQ-040 load_start pulsed during LOAD and RUN -> no effect on counter, load_count or state.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared CPU definitions: datapath defaults, opcode constants and the
// program-loader state encoding.
package imem_loader_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 16;

    localparam logic [15:0] OP_NOP  = 16'h0000;
    localparam logic [15:0] OP_HALT = 16'h0800;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_LOAD = 3'd1,
        LDR_FILL = 3'd2,
        LDR_RUN  = 3'd3,
        LDR_DONE = 3'd4
    } loader_state_e;

    function automatic logic is_halt(input logic [15:0] word);
        return (word == OP_HALT);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a host program into instruction memory, pads the unused tail with
// FILL_WORD, then releases the CPU until it halts.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = CPU_ADDR_W,
    parameter int                DATA_W    = CPU_DATA_W,
    parameter logic [DATA_W-1:0] FILL_WORD = OP_NOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              cpu_halt,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

    loader_state_e     state_r;
    loader_state_e     state_s;
    logic [ADDR_W-1:0] addr_r;
    logic              wr_en_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              at_last_s;
    logic              start_s;

    // The terminal address always closes the write phase, so the counter never wraps.
    assign at_last_s = (addr_r == LAST_ADDR);
    assign start_s   = load_start && ((state_r == LDR_IDLE) || (state_r == LDR_DONE));

    // Next-state and write-request decode
    always_comb begin
        state_s   = state_r;
        wr_en_s   = 1'b0;
        wr_data_s = host_data;
        case (state_r)
            LDR_IDLE, LDR_DONE: begin
                if (load_start) begin
                    state_s = LDR_LOAD;
                end else begin
                    state_s = state_r;
                end
            end
            LDR_LOAD: begin
                if (host_valid && host_ready) begin
                    wr_en_s = 1'b1;
                    if (at_last_s) begin
                        state_s = LDR_RUN;
                    end else if (host_last) begin
                        state_s = LDR_FILL;
                    end else begin
                        state_s = LDR_LOAD;
                    end
                end else begin
                    state_s = LDR_LOAD;
                end
            end
            LDR_FILL: begin
                wr_en_s   = 1'b1;
                wr_data_s = FILL_WORD;
                if (at_last_s) begin
                    state_s = LDR_RUN;
                end else begin
                    state_s = LDR_FILL;
                end
            end
            LDR_RUN: begin
                if (cpu_halt) begin
                    state_s = LDR_DONE;
                end else begin
                    state_s = LDR_RUN;
                end
            end
            default: begin
                state_s = LDR_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LDR_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Write address counter and accepted-word count
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r     <= ADDR_ZERO;
            load_count <= COUNT_ZERO;
        end else if (start_s) begin
            addr_r     <= ADDR_ZERO;
            load_count <= COUNT_ZERO;
        end else if (wr_en_s) begin
            if (!at_last_s) begin
                addr_r <= addr_r + ADDR_ONE;
            end else begin
                addr_r <= addr_r;
            end
            if (state_r == LDR_LOAD) begin
                load_count <= load_count + COUNT_ONE;
            end else begin
                load_count <= load_count;
            end
        end else begin
            addr_r     <= addr_r;
            load_count <= load_count;
        end
    end

    // Registered memory port and status outputs.
    // cpu_run waits one cycle after entering RUN so the final write lands first.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_waddr  <= ADDR_ZERO;
            mem_wdata  <= DATA_ZERO;
            host_ready <= 1'b0;
            busy       <= 1'b0;
            cpu_run    <= 1'b0;
        end else begin
            mem_we <= wr_en_s;
            if (wr_en_s) begin
                mem_waddr <= addr_r;
                mem_wdata <= wr_data_s;
            end else begin
                mem_waddr <= mem_waddr;
                mem_wdata <= mem_wdata;
            end
            host_ready <= (state_s == LDR_LOAD);
            busy       <= (state_s == LDR_LOAD) || (state_s == LDR_FILL);
            cpu_run    <= (state_s == LDR_RUN) && (state_r == LDR_RUN);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a memory-image model.
module tb_imem_loader;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        reset, load_start, host_valid, host_last, cpu_halt;
    logic [15:0] host_data;
    logic        host_ready, mem_we, cpu_run, busy;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic [8:0]  load_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_cyc = -1;
    int ready_miss = 0;
    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    int xfer_cyc[$];
    logic [15:0] prog [0:255];

    imem_loader dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
        .host_ready(host_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .cpu_halt(cpu_halt), .cpu_run(cpu_run),
        .load_count(load_count), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/run monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_addr.push_back(int'(mem_waddr));
            obs_data.push_back(int'(mem_wdata));
            obs_cyc.push_back(cyc);
        end
        if (cpu_run === 1'b1 && run_cyc < 0) run_cyc = cyc;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        run_cyc = -1;
    endtask

    // Expected memory image: program words, then NOP up to the top address.
    function automatic int exp_word(input int i, input int n);
        if (i < n) return int'(prog[i]);
        else return int'(NOP);
    endfunction

    task automatic halt_cpu;
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        tick();
    endtask

    task automatic drive_load(input int n, input bit use_last, input int vmode, input bit poke);
        int idx;
        int g;
        bit v;
        clear_obs();
        xfer_cyc.delete();
        ready_miss = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        idx = 0;
        g = 0;
        while (idx < n && g < 4000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (g % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            host_valid = v;
            host_data  = prog[idx];
            host_last  = use_last && (idx == n - 1);
            load_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (host_ready !== 1'b1) ready_miss++;
            tick();
            if (v) begin
                xfer_cyc.push_back(cyc);
                idx++;
            end
            g++;
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
        host_data  = 16'h0000;
        load_start = 1'b0;
        g = 0;
        while (!(obs_addr.size() >= 256 && run_cyc >= 0) && g < 600) begin
            tick();
            g++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL reset host_ready: got %b expected 0", host_ready); end
        checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL reset cpu_run: got %b expected 0", cpu_run); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we: got %b expected 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if (mem_waddr !== 8'h00) begin errors++; $display("FAIL reset mem_waddr: got %h expected 00", mem_waddr); end
        checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset mem_wdata: got %h expected 0000", mem_wdata); end
        checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL reset load_count: got %0d expected 0", load_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_scenario(input string name, input int n, input bit use_last,
                                      input int vmode, input bit poke, input bit rand_prog);
        int exp_c;
        if (rand_prog) for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
        drive_load(n, use_last, vmode, poke);
        checks++; if (ready_miss != 0) begin errors++; $display("FAIL %s host_ready in LOAD: got %0d low cycles expected 0", name, ready_miss); end
        checks++; if (xfer_cyc.size() != n) begin errors++; $display("FAIL %s transfers: got %0d expected %0d", name, xfer_cyc.size(), n); end
        checks++; if (obs_addr.size() != 256) begin errors++; $display("FAIL %s write count: got %0d expected 256", name, obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 256; i++) begin
            checks++;
            if (obs_addr[i] != i || obs_data[i] != exp_word(i, n)) begin
                errors++;
                $display("FAIL %s write[%0d]: got addr %0d data %h expected addr %0d data %h",
                         name, i, obs_addr[i], obs_data[i], i, exp_word(i, n));
            end
            if (i < n) exp_c = (i < xfer_cyc.size()) ? xfer_cyc[i] : -1;
            else exp_c = obs_cyc[i-1] + 1;
            checks++;
            if (obs_cyc[i] != exp_c) begin
                errors++;
                $display("FAIL %s write[%0d] timing: got cycle %0d expected %0d", name, i, obs_cyc[i], exp_c);
            end
        end
        if (obs_cyc.size() == 256) begin
            checks++;
            if (run_cyc != obs_cyc[255] + 1) begin
                errors++;
                $display("FAIL %s cpu_run rise: got cycle %0d expected %0d", name, run_cyc, obs_cyc[255] + 1);
            end
        end
        @(negedge clk);
        checks++; if (load_count !== 9'(n)) begin errors++; $display("FAIL %s load_count: got %0d expected %0d", name, load_count, n); end
        checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL %s cpu_run in RUN: got %b expected 1", name, cpu_run); end
        checks++; if (busy !== 1'b0 || host_ready !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL %s run outputs busy/ready/we: got %b%b%b expected 000", name, busy, host_ready, mem_we); end
    endtask

    task automatic test_start_in_run(input int exp_cnt);
        clear_obs();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL start_in_run cpu_run: got %b expected 1", cpu_run); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_run busy: got %b expected 0", busy); end
        checks++; if (load_count !== 9'(exp_cnt)) begin errors++; $display("FAIL start_in_run load_count: got %0d expected %0d", load_count, exp_cnt); end
        checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL start_in_run writes: got %0d expected 0", obs_addr.size()); end
    endtask

    task automatic test_halt_reload(input int exp_cnt);
        @(negedge clk);
        checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL halt pre cpu_run: got %b expected 1", cpu_run); end
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        @(negedge clk);
        checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL halt cpu_run: got %b expected 0", cpu_run); end
        checks++; if (busy !== 1'b0 || host_ready !== 1'b0) begin errors++; $display("FAIL halt busy/ready: got %b%b expected 00", busy, host_ready); end
        checks++; if (load_count !== 9'(exp_cnt)) begin errors++; $display("FAIL halt load_count: got %0d expected %0d", load_count, exp_cnt); end
        clear_obs();
        cpu_halt = 1'b1;
        repeat (2) tick();
        cpu_halt = 1'b0;
        @(negedge clk);
        checks++; if (cpu_run !== 1'b0 || obs_addr.size() != 0) begin errors++; $display("FAIL done cpu_run/writes: got %b/%0d expected 0/0", cpu_run, obs_addr.size()); end
        test_load_scenario("reload", 7, 1'b1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_stall_load;
        clear_obs();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        host_valid = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        checks++; if (busy !== 1'b1 || host_ready !== 1'b1) begin errors++; $display("FAIL stall busy/ready: got %b%b expected 11", busy, host_ready); end
        checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL stall writes: got %0d expected 0", obs_addr.size()); end
        checks++; if (load_count !== 9'd0 || cpu_run !== 1'b0) begin errors++; $display("FAIL stall count/run: got %0d/%b expected 0/0", load_count, cpu_run); end
    endtask

    task automatic test_reset_midload;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
        clear_obs();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1;
            host_data  = prog[i];
            host_last  = 1'b0;
            tick();
        end
        host_data = prog[5];
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (obs_addr.size() != 5) begin errors++; $display("FAIL midreset writes before: got %0d expected 5", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 5; i++) begin
            checks++;
            if (obs_addr[i] != i || obs_data[i] != int'(prog[i])) begin errors++; $display("FAIL midreset write[%0d]: got %0d/%h expected %0d/%h", i, obs_addr[i], obs_data[i], i, prog[i]); end
        end
        checks++; if ({host_ready, cpu_run, mem_we, busy} !== 4'b0000) begin errors++; $display("FAIL midreset flags: got %b expected 0000", {host_ready, cpu_run, mem_we, busy}); end
        checks++; if (mem_waddr !== 8'h00 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL midreset port: got %h/%h expected 00/0000", mem_waddr, mem_wdata); end
        checks++; if (load_count !== 9'd0) begin errors++; $display("FAIL midreset load_count: got %0d expected 0", load_count); end
        reset = 1'b0;
        clear_obs();
        repeat (10) tick();
        host_valid = 1'b0;
        @(negedge clk);
        checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL midreset later writes: got %0d expected 0", obs_addr.size()); end
        checks++; if (host_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset idle ready/busy: got %b%b expected 00", host_ready, busy); end
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        host_valid = 1'b0;
        host_data  = 16'h0000;
        host_last  = 1'b0;
        cpu_halt   = 1'b0;
        test_reset();
        prog[0] = 16'h4A09;
        prog[1] = 16'h4A89;
        prog[2] = 16'h0800;
        test_load_scenario("short", 3, 1'b1, 0, 1'b0, 1'b0);
        test_start_in_run(3);
        test_halt_reload(3);
        halt_cpu();
        test_load_scenario("toggle", 10, 1'b1, 1, 1'b1, 1'b1);
        halt_cpu();
        test_load_scenario("full", 256, 1'b0, 0, 1'b0, 1'b1);
        halt_cpu();
        for (int k = 0; k < 2; k++) begin
            test_load_scenario("random", int'($urandom_range(1, 256)), 1'b1, 2, 1'b0, 1'b1);
            halt_cpu();
        end
        test_stall_load();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
